npu_phase_scheduler: RTL and testbench
======================================

# npu_phase_scheduler

Round-robin scheduler that shares one two-phase (load, then compute) processing-element sequence among `NREQ` requesters. It arbitrates, grants the phase engine to one requester at a time, and runs a LOAD phase and a COMPUTE phase of programmable length. It then pulses completion to the owner. It sits between the NPU command front-ends and the phase-driven datapath, and drives the datapath's `phase`/`counter` inputs directly.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `LW`, 3: width of `load_len`
- `CW`, 4: width of `comp_len` and of `counter`; `CW >= LW`
- `clk`  in  1  rising-edge clock, single clock domain
- `rst`  in  1  reset: asynchronous, active-low
- `req`  in  NREQ  level request per requester; held until `done` or dropped to abort
- `load_len`  in  LW  LOAD phase length minus 1; sampled at grant
- `comp_len`  in  CW  COMPUTE phase length minus 1; sampled at grant
- `grant`  out  NREQ  one-hot owner, registered
- `phase`  out  2  00 IDLE, 01 LOAD, 10 COMP, 11 DONE
- `counter`  out  CW  cycle index within current phase
- `done`  out  NREQ  one-cycle completion pulse to owner
- `busy`  out  1  high whenever state != IDLE

## Operation
- Reset (rst=0, immediate): state IDLE; `grant`=0, `done`=0, `counter`=0, `phase`=00, `busy`=0; priority pointer `ptr`=NREQ-1, so index 0 wins first.
- IDLE: when any `req` bit is set, pick the first set bit scanning from `ptr+1` upward with wrap. Next edge: set `grant` one-hot to the winner, latch `load_len`→`L` and `comp_len`→`C`, set `counter`=0 and state LOAD. With no request, stay in IDLE.
- LOAD: `counter` increments 0..L. When `counter`==L, the next edge goes to COMP with `counter`=0. LOAD lasts L+1 cycles.
- COMP: `counter` increments 0..C. When `counter`==C, the next edge goes to DONE. COMP lasts C+1 cycles.
- DONE: lasts 1 cycle. `done[owner]`=1, `grant`=0, `counter`=0, and `ptr` is set to the owner. The next edge goes to IDLE.
- Abort: if `req[owner]` is 0 during a LOAD or COMP cycle, the next edge goes to IDLE. In that transition `grant`=0, `counter`=0 and `ptr`=owner, with no `done` pulse.
- Lengths are frozen for the whole job. Changes on `load_len`/`comp_len` after the grant are ignored.
- Width rule: `L` is zero-extended to CW for comparison. The counter never exceeds max(L,C), so it never wraps.
- Requests from non-owners during a job are ignored. They stay pending and are arbitrated in the next IDLE cycle.
- Reset asserted mid-job returns immediately to the reset values. No `done` pulse is issued.

## Timing
- All outputs are registered. There is no combinational path from `req` to `grant`.
- Request visible in IDLE cycle t: `grant`/LOAD from t+1, COMP from t+1+(L+1), DONE at t+L+C+3, IDLE at t+L+C+4.
- Per-job occupancy, including one IDLE arbitration cycle: L+C+4 cycles. Minimum job (L=0, C=0): 4 cycles.
- `done` coincides with `phase`=11 and `grant`=0. The requester may drop `req` in the DONE cycle or later. If `req` is still high in the following IDLE cycle, it counts as a new request.
- At the end of each job, including aborted jobs, the pointer rotates past the served requester.

## Structure
- Shared package `npu_pkg`:
  - phase encodings `PH_IDLE`, `PH_LOAD`, `PH_COMP`, `PH_DONE`
  - default `NREQ`, `LW` and `CW` values
- Sub-module `npu_rr_pick`: combinational rotate-priority encoder with inputs `req` and `ptr` and outputs one-hot `win`, `win_idx` and `any`. It is reusable by other NPU arbiters.
- Top level holds the state register, the `L`/`C` latches, the counter, `ptr` and the output registers.

## Test plan
- Reset and single job: release `rst`, hold `req`=0001 with L=3, C=14. Required: `grant`=0001 one cycle after the request. `phase`=01 for 4 cycles with `counter` 0..3, then `phase`=10 for 15 cycles with `counter` 0..14. Then `done`=0001 for 1 cycle, then IDLE.
- Round-robin fairness: hold `req`=1111 with L=0, C=0. Required: grant order 0001, 0010, 0100, 1000, 0001, each job 4 cycles apart.
- Length freeze: grant with L=1, C=2, then change the lengths to L=7, C=15 mid-LOAD. Required: LOAD stays 2 cycles and COMP stays 3 cycles.
- Abort: drop `req[2]` at COMP `counter`=5 while `req`=0110. Required: IDLE on the next edge, no `done[2]`, and the next grant goes to 0010 (the wrap-around winner after `ptr`=2).
- Async reset mid-job: assert `rst`=0 at LOAD `counter`=2 with no clock edge. Required: `grant`=0, `phase`=00 and `counter`=0 immediately. After release, the first grant goes to the lowest pending index.
- Late request: assert `req[3]` while `req[0]` is being served. Required: `req[3]` is ignored until DONE, then granted in the following IDLE arbitration.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: phase encodings and default scheduler dimensions.
package npu_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned LW_DEF   = 3;
    localparam int unsigned CW_DEF   = 4;

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_LOAD = 2'b01;
    localparam logic [1:0] PH_COMP = 2'b10;
    localparam logic [1:0] PH_DONE = 2'b11;

    // State encoding equals the phase encoding so the state register drives phase directly.
    typedef enum logic [1:0] {
        ST_IDLE = PH_IDLE,
        ST_LOAD = PH_LOAD,
        ST_COMP = PH_COMP,
        ST_DONE = PH_DONE
    } state_t;

endpackage

// File: rtl/npu_phase_scheduler_if.sv
// Requester/scheduler bundle: request and lengths in, grant/phase/counter/done/busy out.
interface npu_phase_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LW   = 3,
    parameter int unsigned CW   = 4
) ();
    logic [NREQ-1:0] req;
    logic [LW-1:0]   load_len;
    logic [CW-1:0]   comp_len;
    logic [NREQ-1:0] grant;
    logic [1:0]      phase;
    logic [CW-1:0]   counter;
    logic [NREQ-1:0] done;
    logic            busy;

    modport master (
        output req, load_len, comp_len,
        input  grant, phase, counter, done, busy
    );

    modport slave (
        input  req, load_len, comp_len,
        output grant, phase, counter, done, busy
    );
endinterface

// File: rtl/npu_rr_pick.sv
// Rotate-priority encoder: first set req bit scanning upward from ptr+1 with wrap.
module npu_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic [IW-1:0]   o_win_idx,
    output logic            o_any
);
    logic [IW-1:0] w_sel;

    always_comb begin
        o_win     = '0;
        o_win_idx = '0;
        o_any     = 1'b0;
        w_sel     = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            w_sel = IW'((int'(i_ptr) + k) % int'(NREQ));
            if (!o_any && i_req[w_sel]) begin
                o_any        = 1'b1;
                o_win_idx    = w_sel;
                o_win[w_sel] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/npu_phase_scheduler.sv
// Round-robin owner of the shared LOAD/COMPUTE phase engine with registered outputs.
module npu_phase_scheduler
    import npu_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned LW   = LW_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input logic                  clk,
    input logic                  rst,
    npu_phase_scheduler_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic [CW-1:0]   r_counter;
    logic [LW-1:0]   r_l;
    logic [CW-1:0]   r_c;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic            r_busy;

    logic [NREQ-1:0] w_win;
    logic [IW-1:0]   w_win_idx;
    logic            w_any;
    logic            w_owner_req;

    npu_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req     (bus.req),
        .i_ptr     (r_ptr),
        .o_win     (w_win),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    assign w_owner_req = bus.req[r_owner];

    // Job sequencer; an owner dropping req in LOAD/COMP aborts without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_done    <= '0;
            r_counter <= '0;
            r_l       <= '0;
            r_c       <= '0;
            r_ptr     <= IW'(NREQ - 1);
            r_owner   <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    if (w_any) begin
                        r_state   <= ST_LOAD;
                        r_grant   <= w_win;
                        r_owner   <= w_win_idx;
                        r_l       <= bus.load_len;
                        r_c       <= bus.comp_len;
                        r_counter <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!w_owner_req) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= '0;
                        r_counter <= '0;
                        r_ptr     <= r_owner;
                        r_busy    <= 1'b0;
                    end else if (r_counter == CW'(r_l)) begin
                        r_state   <= ST_COMP;
                        r_counter <= '0;
                    end else begin
                        r_counter <= r_counter + CW'(1);
                    end
                end
                ST_COMP: begin
                    if (!w_owner_req) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= '0;
                        r_counter <= '0;
                        r_ptr     <= r_owner;
                        r_busy    <= 1'b0;
                    end else if (r_counter == r_c) begin
                        r_state   <= ST_DONE;
                        r_done    <= r_grant;
                        r_grant   <= '0;
                        r_counter <= '0;
                        r_ptr     <= r_owner;
                    end else begin
                        r_counter <= r_counter + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant   = r_grant;
    assign bus.phase   = r_state;
    assign bus.counter = r_counter;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_npu_phase_scheduler.sv
// Directed bench for npu_phase_scheduler: single job, fairness, freeze, abort, reset, late request.
module tb_npu_phase_scheduler;
    import npu_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    npu_phase_scheduler_if #(.NREQ(4), .LW(3), .CW(4)) bus ();

    npu_phase_scheduler #(.NREQ(4), .LW(3), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: tests=%0d failed=%0d, simulation did not finish", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] e_phase, input logic [3:0] e_cnt,
                       input logic [3:0] e_grant, input logic [3:0] e_done, input logic e_busy);
        n_tests += 5;
        assert (bus.phase === e_phase) else begin
            n_fail++;
            $error("FAIL %s phase: got %b want %b", tag, bus.phase, e_phase);
        end
        assert (bus.counter === e_cnt) else begin
            n_fail++;
            $error("FAIL %s counter: got %0d want %0d", tag, bus.counter, e_cnt);
        end
        assert (bus.grant === e_grant) else begin
            n_fail++;
            $error("FAIL %s grant: got %b want %b", tag, bus.grant, e_grant);
        end
        assert (bus.done === e_done) else begin
            n_fail++;
            $error("FAIL %s done: got %b want %b", tag, bus.done, e_done);
        end
        assert (bus.busy === e_busy) else begin
            n_fail++;
            $error("FAIL %s busy: got %b want %b", tag, bus.busy, e_busy);
        end
    endtask

    logic [3:0] rr_order [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000;
        rr_order[4] = 4'b0001;

        rst          = 1'b0;
        bus.req      = 4'b0000;
        bus.load_len = 3'd0;
        bus.comp_len = 4'd0;
        #12;
        chk("reset", PH_IDLE, 4'd0, 4'b0000, 4'b0000, 1'b0);
        tick();
        rst = 1'b1;

        // Single job, L=3 C=14
        bus.req      = 4'b0001;
        bus.load_len = 3'd3;
        bus.comp_len = 4'd14;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t1_load", PH_LOAD, 4'(i), 4'b0001, 4'b0000, 1'b1);
            tick();
        end
        for (int i = 0; i < 15; i++) begin
            chk("t1_comp", PH_COMP, 4'(i), 4'b0001, 4'b0000, 1'b1);
            tick();
        end
        chk("t1_done", PH_DONE, 4'd0, 4'b0000, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk("t1_idle", PH_IDLE, 4'd0, 4'b0000, 4'b0000, 1'b0);

        // Fairness from a fresh pointer
        rst = 1'b0;
        #1;
        rst = 1'b1;
        bus.req      = 4'b1111;
        bus.load_len = 3'd0;
        bus.comp_len = 4'd0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("rr_load", PH_LOAD, 4'd0, rr_order[j], 4'b0000, 1'b1);
            tick();
            chk("rr_comp", PH_COMP, 4'd0, rr_order[j], 4'b0000, 1'b1);
            tick();
            chk("rr_done", PH_DONE, 4'd0, 4'b0000, rr_order[j], 1'b1);
            if (j == 4) bus.req = 4'b0000;
            tick();
            chk("rr_idle", PH_IDLE, 4'd0, 4'b0000, 4'b0000, 1'b0);
        end

        // Length freeze
        bus.req      = 4'b0001;
        bus.load_len = 3'd1;
        bus.comp_len = 4'd2;
        tick();
        chk("frz_l0", PH_LOAD, 4'd0, 4'b0001, 4'b0000, 1'b1);
        bus.load_len = 3'd7;
        bus.comp_len = 4'd15;
        tick();
        chk("frz_l1", PH_LOAD, 4'd1, 4'b0001, 4'b0000, 1'b1);
        tick();
        chk("frz_c0", PH_COMP, 4'd0, 4'b0001, 4'b0000, 1'b1);
        tick();
        chk("frz_c1", PH_COMP, 4'd1, 4'b0001, 4'b0000, 1'b1);
        tick();
        chk("frz_c2", PH_COMP, 4'd2, 4'b0001, 4'b0000, 1'b1);
        tick();
        chk("frz_done", PH_DONE, 4'd0, 4'b0000, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk("frz_idle", PH_IDLE, 4'd0, 4'b0000, 4'b0000, 1'b0);

        // Abort of owner 2 at COMP counter 5
        bus.req      = 4'b0100;
        bus.load_len = 3'd0;
        bus.comp_len = 4'd9;
        tick();
        chk("ab_load", PH_LOAD, 4'd0, 4'b0100, 4'b0000, 1'b1);
        bus.req = 4'b0110;
        tick();
        chk("ab_c0", PH_COMP, 4'd0, 4'b0100, 4'b0000, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("ab_comp", PH_COMP, 4'(i), 4'b0100, 4'b0000, 1'b1);
        end
        bus.req = 4'b0010;
        tick();
        chk("ab_idle", PH_IDLE, 4'd0, 4'b0000, 4'b0000, 1'b0);
        bus.load_len = 3'd4;
        bus.comp_len = 4'd3;
        tick();
        chk("ab_next", PH_LOAD, 4'd0, 4'b0010, 4'b0000, 1'b1);
        tick();
        chk("ar_l1", PH_LOAD, 4'd1, 4'b0010, 4'b0000, 1'b1);
        tick();
        chk("ar_l2", PH_LOAD, 4'd2, 4'b0010, 4'b0000, 1'b1);

        // Async reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("ar_imm", PH_IDLE, 4'd0, 4'b0000, 4'b0000, 1'b0);
        bus.req = 4'b1010;
        #1;
        rst = 1'b1;
        tick();
        chk("ar_first", PH_LOAD, 4'd0, 4'b0010, 4'b0000, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk("ar_abort", PH_IDLE, 4'd0, 4'b0000, 4'b0000, 1'b0);

        // Late request from requester 3 while 0 is served
        bus.req      = 4'b0001;
        bus.load_len = 3'd1;
        bus.comp_len = 4'd1;
        tick();
        chk("late_l0", PH_LOAD, 4'd0, 4'b0001, 4'b0000, 1'b1);
        bus.req = 4'b1001;
        tick();
        chk("late_l1", PH_LOAD, 4'd1, 4'b0001, 4'b0000, 1'b1);
        tick();
        chk("late_c0", PH_COMP, 4'd0, 4'b0001, 4'b0000, 1'b1);
        tick();
        chk("late_c1", PH_COMP, 4'd1, 4'b0001, 4'b0000, 1'b1);
        tick();
        chk("late_done", PH_DONE, 4'd0, 4'b0000, 4'b0001, 1'b1);
        bus.req = 4'b1000;
        tick();
        chk("late_idle", PH_IDLE, 4'd0, 4'b0000, 4'b0000, 1'b0);
        tick();
        chk("late_grant", PH_LOAD, 4'd0, 4'b1000, 4'b0000, 1'b1);
        bus.req = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
